// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcodes, funct encodings and issue packet type for the
//           integer ALU decode/issue path.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef struct packed {
    logic [ALU_XLEN-1:0] op1;
    logic [ALU_XLEN-1:0] op2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
  } issue_pkt_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/issue_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : issue_skid_buf
// Brief   : Two-entry FIFO skid buffer of issue packets. Ready on the push
//           side is purely registered (no path from the pop side ready).
// Rev     : 1.0  initial release
// ============================================================================
module issue_skid_buf
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push_valid,
  output logic       o_push_ready,
  input  issue_pkt_t i_push_pkt,
  output logic       o_pop_valid,
  input  logic       i_pop_ready,
  output issue_pkt_t o_pop_pkt
);

  buf_state_t r_state;
  buf_state_t w_state_nxt;
  issue_pkt_t r_head;
  issue_pkt_t r_tail;
  logic       w_push;
  logic       w_pop;
  logic       w_load_head_in;
  logic       w_load_head_tail;
  logic       w_load_tail;

  assign o_push_ready = (r_state != BUF_FULL);
  assign o_pop_valid  = (r_state != BUF_EMPTY);
  assign o_pop_pkt    = r_head;

  assign w_push = i_push_valid && o_push_ready;
  assign w_pop  = o_pop_valid && i_pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_tail = 1'b0;
    w_load_tail      = 1'b0;
    unique case (r_state)
      BUF_EMPTY: begin
        if (w_push) begin
          w_state_nxt    = BUF_ONE;
          w_load_head_in = 1'b1;
        end
      end
      BUF_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_state_nxt = BUF_FULL;
            w_load_tail = 1'b1;
          end
          2'b01: begin
            w_state_nxt = BUF_EMPTY;
          end
          2'b11: begin
            w_load_head_in = 1'b1;
          end
          default: ;
        endcase
      end
      BUF_FULL: begin
        // push is impossible here because push ready is low while full
        if (w_pop) begin
          w_state_nxt      = BUF_ONE;
          w_load_head_tail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BUF_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= i_push_pkt;
      end else if (w_load_head_tail) begin
        r_head <= r_tail;
      end
      if (w_load_tail) begin
        r_tail <= i_push_pkt;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue
// Brief   : RV32I OP / OP-IMM decode and issue stage for the integer ALU,
//           with a 2-entry skid buffer. Define ALU_ISSUE_SCOREBOARD_EN to add
//           a RAW-hazard scoreboard released by writeback.
// Rev     : 1.0  initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inst_valid,
  input  logic [31:0]             inst,
  output logic                    inst_ready,
  output logic [$clog2(NREG)-1:0] rs1_addr,
  output logic [$clog2(NREG)-1:0] rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [XLEN-1:0]         iss_op1,
  output logic [XLEN-1:0]         iss_op2,
  output logic [2:0]              iss_funct3,
  output logic [6:0]              iss_funct7,
  output logic [$clog2(NREG)-1:0] iss_rd,
  output logic                    illegal,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_rd
);

  localparam int REG_AW = $clog2(NREG);

  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [REG_AW-1:0] w_rd;
  issue_pkt_t        w_pkt;
  issue_pkt_t        w_head;
  logic              w_legal;
  logic              w_is_alu;
  logic              w_is_rtype;
  logic              w_hazard;
  logic              w_buf_ready;
  logic              w_accept;
  logic              r_illegal;

  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign w_funct3 = inst[14:12];
  assign w_funct7 = inst[31:25];
  assign w_rd     = inst[11:7];

  always_comb begin
    w_pkt        = '0;
    w_pkt.op1    = rs1_data;
    w_pkt.funct3 = w_funct3;
    w_pkt.rd     = w_rd;
    w_legal      = 1'b0;
    w_is_alu     = 1'b0;
    w_is_rtype   = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        w_is_alu     = 1'b1;
        w_is_rtype   = 1'b1;
        w_pkt.op2    = rs2_data;
        w_pkt.funct7 = w_funct7;
        w_legal      = (w_funct7 == 7'd0) ||
                       ((w_funct7 == FUNCT7_ALT) &&
                        ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA)));
      end
      OPC_OP_IMM: begin
        w_is_alu     = 1'b1;
        w_pkt.op2    = {{(XLEN-12){inst[31]}}, inst[31:20]};
        // funct7 stays zero for plain immediates: the ALU reads nonzero as SUB
        w_pkt.funct7 = 7'd0;
        w_legal      = 1'b1;
        if (w_funct3 == F3_SLL) begin
          w_pkt.op2 = {{(XLEN-5){1'b0}}, inst[24:20]};
          w_legal   = (w_funct7 == 7'd0);
        end else if (w_funct3 == F3_SRL_SRA) begin
          w_pkt.op2    = {{(XLEN-5){1'b0}}, inst[24:20]};
          w_pkt.funct7 = w_funct7;
          w_legal      = (w_funct7 == 7'd0) || (w_funct7 == FUNCT7_ALT);
        end
      end
      default: ;
    endcase
  end

  assign inst_ready = w_buf_ready && !w_hazard;
  assign w_accept   = inst_valid && inst_ready;

`ifdef ALU_ISSUE_SCOREBOARD_EN
  logic [NREG-1:1] r_busy;
  logic [NREG-1:0] w_busy_vec;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_set;

  assign w_busy_vec = {r_busy, 1'b0};
  // a writeback to the source in the same cycle releases it (write-through)
  assign w_rs1_hit  = w_busy_vec[rs1_addr] && !(wb_valid && (wb_rd == rs1_addr));
  assign w_rs2_hit  = w_busy_vec[rs2_addr] && !(wb_valid && (wb_rd == rs2_addr));
  assign w_hazard   = w_is_alu && (w_rs1_hit || (w_is_rtype && w_rs2_hit));
  assign w_set      = w_accept && w_legal && (w_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_set && (w_rd == REG_AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (wb_valid && (wb_rd == REG_AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_sb;

  assign w_hazard    = 1'b0;
  assign w_unused_sb = ^{wb_valid, wb_rd, w_is_alu, w_is_rtype};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
    end
  end

  assign illegal = r_illegal;

  issue_skid_buf u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (w_accept && w_legal),
    .o_push_ready (w_buf_ready),
    .i_push_pkt   (w_pkt),
    .o_pop_valid  (iss_valid),
    .i_pop_ready  (iss_ready),
    .o_pop_pkt    (w_head)
  );

  assign iss_op1    = w_head.op1;
  assign iss_op2    = w_head.op2;
  assign iss_funct3 = w_head.funct3;
  assign iss_funct7 = w_head.funct7;
  assign iss_rd     = w_head.rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue
// Brief   : Directed bench for alu_issue against an instruction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_issue;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        inst_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [31:0] iss_op1, iss_op2;
  logic [2:0]  iss_funct3;
  logic [6:0]  iss_funct7;
  logic [4:0]  iss_rd;
  logic        illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;

  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  exp_t        q[$];
  logic        exp_illegal = 1'b0;
  logic [31:0] mbusy = 32'd0;

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  alu_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_op1    (iss_op1),
    .iss_op2    (iss_op2),
    .iss_funct3 (iss_funct3),
    .iss_funct7 (iss_funct7),
    .iss_rd     (iss_rd),
    .illegal    (illegal),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd)
  );

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, IMM};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what the ALU must see for a given word.
  function automatic void model_decode(input logic [31:0] w, output bit legal, output exp_t p);
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    legal = 0;
    p.op1 = rf[w[19:15]];
    p.op2 = 32'd0;
    p.f3  = f3;
    p.f7  = 7'd0;
    p.rd  = w[11:7];
    if (w[6:0] == OP) begin
      p.op2 = rf[w[24:20]];
      p.f7  = f7;
      legal = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (w[6:0] == IMM) begin
      p.op2 = 32'($signed(w[31:20]));
      legal = 1;
      if (f3 == 3'd1) begin
        p.op2 = 32'(w[24:20]);
        legal = (f7 == 7'd0);
      end else if (f3 == 3'd5) begin
        p.op2 = 32'(w[24:20]);
        p.f7  = f7;
        legal = (f7 == 7'd0) || (f7 == 7'h20);
      end
    end
  endfunction

  function automatic bit model_ready();
    bit hz = 0;
`ifdef ALU_ISSUE_SCOREBOARD_EN
    logic [4:0] a = inst[19:15];
    logic [4:0] b = inst[24:20];
    bit alu = (inst[6:0] == OP) || (inst[6:0] == IMM);
    if (alu && a != 0 && mbusy[a] && !(wb_valid && wb_rd == a)) hz = 1;
    if (inst[6:0] == OP && b != 0 && mbusy[b] && !(wb_valid && wb_rd == b)) hz = 1;
`endif
    return (q.size() < 2) && !hz;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit   rdy, lg, acc;
    exp_t p;
    if (!rst_n) begin
      q.delete();
      exp_illegal <= 1'b0;
      mbusy       <= 32'd0;
    end else begin
      rdy = model_ready();
      model_decode(inst, lg, p);
      acc = inst_valid && rdy;
      if (q.size() > 0 && iss_ready) void'(q.pop_front());
      if (acc && lg) q.push_back(p);
      exp_illegal <= acc && !lg;
`ifdef ALU_ISSUE_SCOREBOARD_EN
      if (wb_valid && wb_rd != 0) mbusy[wb_rd] <= 1'b0;
      if (acc && lg && p.rd != 0) mbusy[p.rd] <= 1'b1;
`endif
    end
  end

  always @(negedge clk) begin : compare
    chk("inst_ready", 32'(inst_ready), 32'(model_ready()));
    chk("iss_valid", 32'(iss_valid), 32'(q.size() > 0));
    chk("illegal", 32'(illegal), 32'(exp_illegal));
    if (q.size() > 0 && iss_valid) begin
      chk("op1", iss_op1, q[0].op1);
      chk("op2", iss_op2, q[0].op2);
      chk("funct3", 32'(iss_funct3), 32'(q[0].f3));
      chk("funct7", 32'(iss_funct7), 32'(q[0].f7));
      chk("rd", 32'(iss_rd), 32'(q[0].rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    inst       = w;
    inst_valid = 1'b1;
    #1;
    while (!inst_ready && n < 40) begin
      step();
      n++;
    end
    if (!inst_ready) begin
      errors++;
      $display("FAIL accept_timeout: inst %08h not accepted in %0d cycles", w, n);
    end else begin
      step();
    end
    inst_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: run did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stim
    logic [31:0] vecs [10];
    logic [31:0] w;

    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    rf[1] = 32'd5;
    rf[2] = 32'd7;

    step(); step();
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_op1", iss_op1, 32'd0);
    chk("rst_rd", 32'(iss_rd), 32'd0);
    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
    #1;
    chk("add_valid", 32'(iss_valid), 32'd1);
    chk("add_op1", iss_op1, 32'd5);
    chk("add_op2", iss_op2, 32'd7);
    chk("add_f3", 32'(iss_funct3), 32'd0);
    chk("add_f7", 32'(iss_funct7), 32'd0);
    chk("add_rd", 32'(iss_rd), 32'd3);

    // ADDI x4,x1,-1
    rf[1] = 32'd10;
    send(itype(12'hFFF, 5'd1, 3'd0, 5'd4));
    #1;
    chk("addi_op1", iss_op1, 32'd10);
    chk("addi_op2", iss_op2, 32'hFFFF_FFFF);
    chk("addi_f7", 32'(iss_funct7), 32'd0);
    chk("addi_rd", 32'(iss_rd), 32'd4);

    // SRAI x5,x1,3
    send(itype({7'h20, 5'd3}, 5'd1, 3'd5, 5'd5));
    #1;
    chk("srai_op2", iss_op2, 32'd3);
    chk("srai_f7", 32'(iss_funct7), 32'h20);
    chk("srai_rd", 32'(iss_rd), 32'd5);

    // SLLI with funct7=0x20 is illegal
    send(itype({7'h20, 5'd2}, 5'd1, 3'd1, 5'd6));
    #1;
    chk("slli_bad_illegal", 32'(illegal), 32'd1);
    chk("slli_bad_valid", 32'(iss_valid), 32'd0);
    step();
    chk("slli_bad_pulse", 32'(illegal), 32'd0);

    // assorted patterns, back to back
    rf[1] = 32'h8000_0001;
    rf[2] = 32'hFFFF_FFF0;
    vecs[0] = rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd8);
    vecs[1] = rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd8);
    vecs[2] = itype(12'h7FF, 5'd2, 3'd4, 5'd9);
    vecs[3] = itype(12'h800, 5'd1, 3'd3, 5'd10);
    vecs[4] = rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd11);
    vecs[5] = rtype(7'h01, 5'd2, 5'd1, 3'd6, 5'd12);
    vecs[6] = {12'h004, 5'd1, 3'd2, 5'd13, 7'b0000011};
    vecs[7] = itype({7'h01, 5'd4}, 5'd1, 3'd5, 5'd14);
    vecs[8] = itype({7'h00, 5'd31}, 5'd2, 3'd5, 5'd15);
    vecs[9] = itype(12'hA5A, 5'd2, 3'd7, 5'd0);
    for (int i = 0; i < 10; i++) send(vecs[i]);
    step(); step();

    // backpressure and ordering
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    iss_ready = 1'b0;
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd7));
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd8));
    w          = rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd9);
    inst       = w;
    inst_valid = 1'b1;
    #1;
    chk("bp_full_ready", 32'(inst_ready), 32'd0);
    chk("bp_head_rd", 32'(iss_rd), 32'd7);
    step(); step();
    iss_ready = 1'b1;
    step();
    #1;
    chk("bp_second_rd", 32'(iss_rd), 32'd8);
    send(w);
    step(); step();

`ifdef ALU_ISSUE_SCOREBOARD_EN
    // RAW on x3 holds the consumer until writeback of x3
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
    inst       = rtype(7'd0, 5'd1, 5'd3, 3'd0, 5'd6);
    inst_valid = 1'b1;
    #1;
    chk("sb_stall", 32'(inst_ready), 32'd0);
    step(); step();
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    rf[3]    = 32'd12;
    #1;
    chk("sb_release", 32'(inst_ready), 32'd1);
    step();
    wb_valid   = 1'b0;
    inst_valid = 1'b0;
    #1;
    chk("sb_op1_after_wb", iss_op1, 32'd12);
    send(itype(12'd1, 5'd1, 3'd0, 5'd0));
    inst       = rtype(7'd0, 5'd0, 5'd0, 3'd0, 5'd7);
    inst_valid = 1'b1;
    #1;
    chk("sb_x0_no_stall", 32'(inst_ready), 32'd1);
    send(inst);
    step(); step();
`endif

    // reset with a full buffer
    iss_ready = 1'b0;
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
    send(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(iss_valid), 32'd0);
    chk("mid_rst_illegal", 32'(illegal), 32'd0);
    chk("mid_rst_op1", iss_op1, 32'd0);
    chk("mid_rst_op2", iss_op2, 32'd0);
    chk("mid_rst_rd", 32'(iss_rd), 32'd0);
    step(); step();
    rst_n     = 1'b1;
    iss_ready = 1'b1;
    w          = rtype(7'd0, 5'd4, 5'd3, 3'd0, 5'd5);
    inst       = w;
    inst_valid = 1'b1;
    #1;
    chk("post_rst_ready", 32'(inst_ready), 32'd1);
    send(w);
    #1;
    chk("post_rst_issue", 32'(iss_valid), 32'd1);
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
